ram_arbiter: RTL
================

# ram_arbiter

Two-requester round-robin arbiter and sequencer for the 64x8 `single_port_ram`. After reset it zero-fills the RAM, then shares the RAM's single port between requester 0 and requester 1, with at most one access per cycle. Read data returns to the issuing requester with a fixed 2-cycle latency. The block sits between two client datapaths and the RAM instance; it drives the RAM's `data`, `addr` and `we` pins and samples its `q`.

## Interface

Parameters:

- DATA_W, 8: RAM word width.
- ADDR_W, 6: RAM address width; depth is 2^ADDR_W.
- INIT_EN, 1: 1 means zero-fill the RAM after reset; 0 means skip the fill.

Ports:

- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request from requester 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read; qualified by req.
- addr0 / addr1  in  ADDR_W  access address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  grant; an access transfers in any cycle where req&gnt.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata is valid for this requester.
- rdata0 / rdata1  out  DATA_W  read data; holds its last value.
- init_done  out  1  high once the fill is complete and arbitration is running.
- ram_data  out  DATA_W  to RAM `data`.
- ram_addr  out  ADDR_W  to RAM `addr`.
- ram_we  out  1  to RAM `we`.
- ram_q  in  DATA_W  from RAM `q`; valid the cycle after its address is presented.

## Operation

- State machine: INIT -> RUN.
  - rst forces INIT and sets the fill counter to 0.
  - With INIT_EN=0, INIT lasts exactly one cycle with ram_we=0.
- INIT (INIT_EN=1):
  - ram_we=1, ram_addr=counter, ram_data=0.
  - Counter increments each cycle from 0 to 2^ADDR_W-1.
  - Move to RUN after the write to the last address; the counter wraps to 0 without a write.
  - gnt0=gnt1=0 throughout.
- RUN, arbitration (combinational from req and the pointer):
  - Only one requester asserts req: grant it.
  - Both assert req: grant the one not granted most recently.
  - Pointer reset value = 1, so requester 0 wins the first contention.
  - The pointer updates only in cycles with a grant.
- RUN, RAM drive:
  - When a grant is given, ram_addr/ram_data/ram_we = the granted requester's addr/wdata/we.
  - With no grant: ram_we=0, ram_addr=0, ram_data=0.
- Requester rule: req, we, addr and wdata stay stable until granted. The arbiter does not check this; violating it gives undefined results.
- Read pipeline:
  - A granted read loads stage-1 {valid, id}.
  - The next cycle captures ram_q into rdata[id], and rvalid[id] pulses in the following cycle.
  - Writes produce no rvalid.
- init_done = (state==RUN), registered.

## Timing

- Reset values:
  - gnt0/1=0, rvalid0/1=0, rdata0/1=0, init_done=0.
  - ram_we=0 while rst is high.
  - state=INIT, counter=0, pointer=1, pipeline valid=0.
- Fill takes 2^ADDR_W cycles (64 by default). init_done rises in the cycle after the last fill write.
- Read granted in cycle N:
  - RAM addr registered at the end of N; ram_q valid in N+1.
  - rdata/rvalid visible in N+2.
  - Latency is 2 cycles.
- Throughput is one access per cycle. Back-to-back reads from either requester pipeline with no bubbles.
- Write granted in cycle N is stored at the end of N. A read of the same address granted in N+1 returns the new data.
- Simultaneous requests alternate strictly while both are held: 0, 1, 0, 1, …
- Reset asserted mid-operation:
  - In-flight reads are dropped; no rvalid is produced.
  - The fill restarts from address 0.

## Test plan

- Reset, then idle: init_done=0 for 64 cycles with ram_we=1 and ram_addr 0..63, ram_data=0; init_done=1 at cycle 65. Then read addr 5 from requester 0 -> rvalid0 two cycles after grant with rdata0=8'h00.
- Requester 0 writes 8'h01/02/03 to addresses 0/1/2, then reads 0, 1, 2 back to back -> rvalid0 on 3 consecutive cycles with rdata0 01, 02, 03; rvalid1 stays 0.
- Both requesters hold req for 6 cycles, requester 0 reading addr 1 and requester 1 reading addr 2 -> grants alternate 0, 1, 0, 1, 0, 1 (requester 0 first); each rvalid carries its own data with no cross-delivery.
- Requester 1 writes 8'hA5 to addr 63, then reads addr 63 the next cycle -> rdata1=8'hA5. A write-only burst produces no rvalid.
- Assert rst one cycle after a read grant -> no rvalid, outputs at their reset values, and the fill restarts at addr 0.
- INIT_EN=0: init_done=1 on the second cycle after rst deasserts, with no RAM writes during INIT.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle between the ram_arbiter, its two client datapaths and the
// single-port RAM. The slave modport is the arbiter's view.
//
// Signals (all synchronous to the arbiter clock):
//   req0/1, we0/1, addr0/1, wdata0/1 : client requests (client -> arbiter)
//   gnt0/1                           : grants (arbiter -> client)
//   rvalid0/1, rdata0/1              : read returns (arbiter -> client)
//   init_done                        : fill finished, arbitration running
//   ram_data, ram_addr, ram_we       : RAM write/address pins (arbiter -> RAM)
//   ram_q                            : RAM read data (RAM -> arbiter)
interface ram_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              init_done;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    // Environment side: both clients plus the RAM instance.
    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1,
        input  rdata0, rdata1, init_done,
        input  ram_data, ram_addr, ram_we,
        output ram_q
    );

    // Arbiter side.
    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1,
        output rdata0, rdata1, init_done,
        output ram_data, ram_addr, ram_we,
        input  ram_q
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port RAM.
// Zero-fills the RAM after reset, then grants at most one access per cycle
// and returns read data to the issuing requester two cycles after grant.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : ram_arbiter_if.slave (client requests/grants/read returns,
//         RAM data/addr/we pins and RAM q)
module ram_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter bit INIT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    // Requester granted most recently; 1 at reset so requester 0 wins first.
    logic              ptr_q, ptr_d;
    // Read stage 1: RAM address presented, q arrives next cycle.
    logic              s1_vld_q, s1_vld_d;
    logic              s1_id_q, s1_id_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              done_q, done_d;

    logic              gnt0_c;
    logic              gnt1_c;
    logic              ram_we_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_data_c;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        s1_vld_d   = 1'b0;
        s1_id_d    = s1_id_q;
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        ram_we_c   = 1'b0;
        ram_addr_c = '0;
        ram_data_c = '0;

        unique case (state_q)
            S_INIT: begin
                if (INIT_EN) begin
                    ram_we_c   = 1'b1;
                    ram_addr_c = cnt_q;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.req0 && bus.req1) begin
                    gnt0_c = ptr_q;
                    gnt1_c = !ptr_q;
                end else begin
                    gnt0_c = bus.req0;
                    gnt1_c = bus.req1;
                end

                if (gnt0_c) begin
                    ram_we_c   = bus.we0;
                    ram_addr_c = bus.addr0;
                    ram_data_c = bus.wdata0;
                    ptr_d      = 1'b0;
                    s1_vld_d   = !bus.we0;
                    s1_id_d    = 1'b0;
                end else if (gnt1_c) begin
                    ram_we_c   = bus.we1;
                    ram_addr_c = bus.addr1;
                    ram_data_c = bus.wdata1;
                    ptr_d      = 1'b1;
                    s1_vld_d   = !bus.we1;
                    s1_id_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Stage 2: q of the stage-1 address is valid now; latch it for the
    // issuing requester and pulse its rvalid next cycle.
    always_comb begin
        rvalid0_d = s1_vld_q && !s1_id_q;
        rvalid1_d = s1_vld_q && s1_id_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (rvalid0_d) begin
            rdata0_d = bus.ram_q;
        end
        if (rvalid1_d) begin
            rdata1_d = bus.ram_q;
        end
        done_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            ptr_q     <= 1'b1;
            s1_vld_q  <= 1'b0;
            s1_id_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_id_q   <= s1_id_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            done_q    <= done_d;
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.init_done = done_q;
    // The fill state would otherwise drive we=1 straight out of reset.
    assign bus.ram_we    = ram_we_c && !rst;
    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_data  = ram_data_c;

    a_gnt_onehot: assert property (
        @(posedge clk) disable iff (rst) !(bus.gnt0 && bus.gnt1)
    );
    a_gnt_has_req: assert property (
        @(posedge clk) disable iff (rst)
        (!bus.gnt0 || bus.req0) && (!bus.gnt1 || bus.req1)
    );

endmodule
